// File: rtl/dcache_linefill.sv
// Data-cache line fill engine: optionally writes the old line back to memory
// word by word, then refills the line from memory and streams it into the
// cache through the line-side port.
module dcache_linefill #(
    parameter int DATABITS      = 32,
    parameter int CACHEADDRBITS = 5,
    parameter int ADDRBITS      = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     dirty,
    input  logic [ADDRBITS-1:0]      old_base,
    input  logic [ADDRBITS-1:0]      new_base,
    output logic                     busy,
    output logic                     done,
    output logic                     flush_mode,
    output logic [CACHEADDRBITS-1:0] flush_addr,
    output logic                     flush_write,
    output logic                     line_in_valid,
    output logic [DATABITS-1:0]      line_in,
    input  logic [DATABITS-1:0]      data_out,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRBITS-1:0]      mem_addr,
    output logic [DATABITS-1:0]      mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATABITS-1:0]      mem_rdata
);
    // Base address bits above the line offset; the offset itself is dropped.
    localparam int HI = ADDRBITS - CACHEADDRBITS - 2;
    localparam logic [CACHEADDRBITS-1:0] IDX_ONE  = 1;
    localparam logic [CACHEADDRBITS-1:0] IDX_LAST = '1;

    typedef enum logic [2:0] {IDLE, WB_ADDR, WB_WRITE, FILL, DONE} state_t;

    state_t                   state, state_n;
    logic [CACHEADDRBITS-1:0] idx, idx_n;
    logic [HI-1:0]            old_hi, new_hi;
    logic                     fill_wr;
    logic [CACHEADDRBITS-1:0] fill_addr;
    logic [DATABITS-1:0]      fill_data;

    // State and word index. The dirty flag needs no register: it is consumed
    // by the IDLE branch decision in the same cycle start is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // Capture line bases at request time so the caller may change them freely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            old_hi <= '0;
            new_hi <= '0;
        end else if (state == IDLE && start) begin
            old_hi <= old_base[ADDRBITS-1 -: HI];
            new_hi <= new_base[ADDRBITS-1 -: HI];
        end
    end

    // Register returned fill data into a one-cycle cache write; the last one
    // lands in the same cycle as DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_wr   <= 1'b0;
            fill_addr <= '0;
            fill_data <= '0;
        end else begin
            fill_wr <= (state == FILL) && mem_ack;
            if ((state == FILL) && mem_ack) begin
                fill_addr <= idx;
                fill_data <= mem_rdata;
            end
        end
    end

    assign flush_write   = fill_wr;
    assign line_in_valid = fill_wr;
    assign line_in       = fill_data;

    // Next-state and per-state outputs. mem_ack only matters in WB_WRITE/FILL.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        busy       = 1'b1;
        flush_mode = 1'b1;
        done       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        flush_addr = fill_addr;
        case (state)
            IDLE: begin
                busy       = 1'b0;
                flush_mode = 1'b0;
                if (start) begin
                    idx_n   = '0;
                    state_n = dirty ? WB_ADDR : FILL;
                end
            end
            WB_ADDR: begin
                // One cycle for the synchronous cache read to produce data_out.
                flush_addr = idx;
                state_n    = WB_WRITE;
            end
            WB_WRITE: begin
                flush_addr = idx;
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = {old_hi, idx, 2'b00};
                mem_wdata  = data_out;
                if (mem_ack) begin
                    if (idx == IDX_LAST) begin
                        idx_n   = '0;
                        state_n = FILL;
                    end else begin
                        idx_n   = idx + IDX_ONE;
                        state_n = WB_ADDR;
                    end
                end
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {new_hi, idx, 2'b00};
                if (mem_ack) begin
                    if (idx == IDX_LAST) begin
                        idx_n   = '0;
                        state_n = DONE;
                    end else begin
                        idx_n = idx + IDX_ONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dcache_linefill.sv
// Directed bench for dcache_linefill: drives a cache read model and a memory
// responder cycle by cycle and checks recorded traffic against fixed values.
module tb_dcache_linefill;
    localparam int DW = 32, CW = 5, AW = 32, N = 32;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, dirty = 1'b0;
    logic [AW-1:0] old_base = '0, new_base = '0;
    logic          busy, done, flush_mode, flush_write, line_in_valid;
    logic [CW-1:0] flush_addr;
    logic [DW-1:0] line_in, data_out = '0, mem_wdata, mem_rdata = '0;
    logic          mem_req, mem_we, mem_ack = 1'b0;
    logic [AW-1:0] mem_addr;

    dcache_linefill #(.DATABITS(DW), .CACHEADDRBITS(CW), .ADDRBITS(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .dirty(dirty),
        .old_base(old_base), .new_base(new_base), .busy(busy), .done(done),
        .flush_mode(flush_mode), .flush_addr(flush_addr), .flush_write(flush_write),
        .line_in_valid(line_in_valid), .line_in(line_in), .data_out(data_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] cache [N];
    int n_chk = 0, n_fail = 0;

    // Traffic recorded by run_op
    logic [AW-1:0] rd_addr [64], wr_addr [64];
    logic [DW-1:0] wr_data [64], fw_data [64];
    logic [CW-1:0] fw_addr [64];
    int wr_cyc [64];
    int rd_n, wr_n, fw_n, done_cyc, stab_err, fw_err, done_fw_ok;
    logic post_busy, post_done;

    function automatic logic [DW-1:0] rdat(input logic [AW-1:0] a);
        return 32'h5EED0000 | {16'h0, a[15:0]};
    endfunction

    // Runs one request to completion (or budget); memory acks after 'delay'
    // waiting cycles. With poke set, start/dirty/bases are disturbed mid-run.
    task automatic run_op(input logic d, input int delay, input int budget, input logic poke);
        int cyc, w;
        logic pend, p_we;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_wdata;
        logic [CW-1:0] fa;
        rd_n = 0; wr_n = 0; fw_n = 0; done_cyc = -1; stab_err = 0; fw_err = 0;
        done_fw_ok = 0; w = 0; pend = 0; cyc = 0;
        p_we = 0; p_addr = '0; p_wdata = '0;
        mem_ack = 0; dirty = d; start = 1;
        @(negedge clk);
        while (done_cyc < 0 && cyc < budget) begin
            cyc++;
            start = poke && (cyc == 5);
            if (poke && cyc == 5) begin
                dirty = ~d; new_base = 32'hDEAD0000; old_base = 32'hBEEF0000;
            end
            if (flush_write) begin
                if (fw_n >= rd_n || mem_we || line_in_valid !== 1'b1) fw_err++;
                if (fw_n < 64) begin fw_addr[fw_n] = flush_addr; fw_data[fw_n] = line_in; end
                fw_n++;
            end
            if (done) begin
                done_cyc = cyc;
                done_fw_ok = (flush_write && flush_addr == CW'(N-1)) ? 1 : 0;
            end
            if (pend && (!mem_req || mem_addr !== p_addr || mem_wdata !== p_wdata || mem_we !== p_we))
                stab_err++;
            mem_ack = 0;
            pend = 0;
            if (mem_req) begin
                if (w == delay) begin
                    mem_ack = 1; w = 0;
                    if (mem_we) begin
                        if (wr_n < 64) begin
                            wr_addr[wr_n] = mem_addr; wr_data[wr_n] = mem_wdata; wr_cyc[wr_n] = cyc;
                        end
                        wr_n++;
                    end else begin
                        mem_rdata = rdat(mem_addr);
                        if (rd_n < 64) rd_addr[rd_n] = mem_addr;
                        rd_n++;
                    end
                end else begin
                    w++; pend = 1; p_addr = mem_addr; p_wdata = mem_wdata; p_we = mem_we;
                end
            end
            fa = flush_addr;
            @(posedge clk); #1 data_out = cache[fa];
            @(negedge clk);
        end
        mem_ack = 0; start = 0;
        post_busy = busy; post_done = done;
    endtask

    task automatic test_reset();
        n_chk++; if (busy !== 0 || done !== 0 || flush_mode !== 0) begin
            n_fail++; $display("FAIL reset_ctrl busy=%b done=%b fmode=%b required 0", busy, done, flush_mode); end
        n_chk++; if (mem_req !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
            n_fail++; $display("FAIL reset_mem req=%b we=%b addr=%h wdata=%h required 0", mem_req, mem_we, mem_addr, mem_wdata); end
        n_chk++; if (flush_write !== 0 || line_in_valid !== 0 || flush_addr !== 0 || line_in !== 0) begin
            n_fail++; $display("FAIL reset_line fw=%b liv=%b fa=%h li=%h required 0", flush_write, line_in_valid, flush_addr, line_in); end
    endtask

    task automatic test_clean_fill();
        old_base = 32'h2000; new_base = 32'h1000;
        run_op(0, 0, 200, 0);
        n_chk++; if (rd_n != N || wr_n != 0 || fw_n != N) begin
            n_fail++; $display("FAIL clean_counts rd=%0d wr=%0d fw=%0d required 32/0/32", rd_n, wr_n, fw_n); end
        for (int k = 0; k < N && k < rd_n && k < fw_n; k++) begin
            n_chk++; if (rd_addr[k] !== 32'h1000 + 4*k) begin
                n_fail++; $display("FAIL clean_rd_addr[%0d] got %h required %h", k, rd_addr[k], 32'h1000 + 4*k); end
            n_chk++; if (fw_addr[k] !== CW'(k) || fw_data[k] !== rdat(32'h1000 + 4*k)) begin
                n_fail++; $display("FAIL clean_fw[%0d] got %h/%h required %h/%h", k, fw_addr[k], fw_data[k], k, rdat(32'h1000 + 4*k)); end
        end
        n_chk++; if (done_cyc != 33 || done_fw_ok != 1) begin
            n_fail++; $display("FAIL clean_done cycle=%0d with_write=%0d required 33/1", done_cyc, done_fw_ok); end
        n_chk++; if (fw_err != 0 || post_busy !== 0 || post_done !== 0) begin
            n_fail++; $display("FAIL clean_tail fw_err=%0d busy=%b done=%b required 0/0/0", fw_err, post_busy, post_done); end
    endtask

    task automatic test_dirty();
        old_base = 32'h2000; new_base = 32'h1000;
        run_op(1, 0, 300, 0);
        n_chk++; if (wr_n != N || rd_n != N || fw_n != N) begin
            n_fail++; $display("FAIL dirty_counts wr=%0d rd=%0d fw=%0d required 32/32/32", wr_n, rd_n, fw_n); end
        for (int k = 0; k < N && k < wr_n; k++) begin
            n_chk++; if (wr_addr[k] !== 32'h2000 + 4*k || wr_data[k] !== 32'hA5000000 + k) begin
                n_fail++; $display("FAIL dirty_wr[%0d] got %h/%h required %h/%h", k, wr_addr[k], wr_data[k], 32'h2000 + 4*k, 32'hA5000000 + k); end
            n_chk++; if (wr_cyc[k] - (k == 0 ? 0 : wr_cyc[k-1]) < 2) begin
                n_fail++; $display("FAIL dirty_spacing[%0d] got %0d required >=2", k, wr_cyc[k] - (k == 0 ? 0 : wr_cyc[k-1])); end
        end
        n_chk++; if (rd_n > 0 && rd_addr[0] !== 32'h1000) begin
            n_fail++; $display("FAIL dirty_first_rd got %h required 00001000", rd_addr[0]); end
        n_chk++; if (done_cyc != 97 || done_fw_ok != 1 || fw_err != 0) begin
            n_fail++; $display("FAIL dirty_done cycle=%0d with_write=%0d fw_err=%0d required 97/1/0", done_cyc, done_fw_ok, fw_err); end
    endtask

    task automatic test_ack_delay();
        old_base = 32'h2000; new_base = 32'h1000;
        run_op(1, 3, 400, 0);
        n_chk++; if (stab_err != 0 || fw_err != 0) begin
            n_fail++; $display("FAIL delay_stable stab_err=%0d fw_err=%0d required 0/0", stab_err, fw_err); end
        n_chk++; if (wr_n != N || rd_n != N || fw_n != N || done_cyc != 289) begin
            n_fail++; $display("FAIL delay_dirty wr=%0d rd=%0d fw=%0d done=%0d required 32/32/32/289", wr_n, rd_n, fw_n, done_cyc); end
        n_chk++; if (wr_n > 31 && wr_data[31] !== 32'hA500001F) begin
            n_fail++; $display("FAIL delay_wdata31 got %h required a500001f", wr_data[31]); end
        run_op(0, 3, 200, 0);
        n_chk++; if (stab_err != 0 || fw_err != 0 || done_cyc != 129 || fw_n != N) begin
            n_fail++; $display("FAIL delay_clean stab=%0d fw_err=%0d done=%0d fw=%0d required 0/0/129/32", stab_err, fw_err, done_cyc, fw_n); end
    endtask

    task automatic test_ignored_inputs();
        // ack while idle must not start anything
        mem_ack = 1; mem_rdata = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (busy !== 0 || mem_req !== 0 || flush_write !== 0 || done !== 0) begin
                n_fail++; $display("FAIL idle_ack busy=%b req=%b fw=%b done=%b required 0", busy, mem_req, flush_write, done); end
        end
        mem_ack = 0;
        // start while busy, with bases and dirty disturbed; offset bits in base
        old_base = 32'h2000; new_base = 32'h3055;
        run_op(0, 0, 200, 1);
        n_chk++; if (rd_n != N || wr_n != 0 || done_cyc != 33 || fw_err != 0) begin
            n_fail++; $display("FAIL busy_start rd=%0d wr=%0d done=%0d fw_err=%0d required 32/0/33/0", rd_n, wr_n, done_cyc, fw_err); end
        n_chk++; if (rd_n > 31 && (rd_addr[0] !== 32'h3000 || rd_addr[31] !== 32'h307C)) begin
            n_fail++; $display("FAIL busy_start_addr got %h..%h required 00003000..0000307c", rd_addr[0], rd_addr[31]); end
    endtask

    task automatic test_reset_mid();
        old_base = 32'h2000; new_base = 32'h1000;
        dirty = 0; start = 1;
        @(negedge clk);
        start = 0; mem_ack = 1; mem_rdata = 32'hCAFE0000;
        repeat (10) @(negedge clk);
        mem_ack = 0;
        n_chk++; if (mem_addr !== 32'h1028 || flush_addr !== CW'(9) || !busy) begin
            n_fail++; $display("FAIL mid_pos addr=%h fa=%h busy=%b required 00001028/09/1", mem_addr, flush_addr, busy); end
        reset = 1; #1;
        n_chk++; if (busy !== 0 || flush_mode !== 0 || mem_req !== 0 || mem_addr !== 0 || flush_addr !== 0 || flush_write !== 0 || line_in !== 0) begin
            n_fail++; $display("FAIL mid_reset busy=%b fm=%b req=%b addr=%h fa=%h fw=%b li=%h required 0", busy, flush_mode, mem_req, mem_addr, flush_addr, flush_write, line_in); end
        @(negedge clk); reset = 0;
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 0 || mem_req !== 0) begin
            n_fail++; $display("FAIL mid_no_resume busy=%b req=%b required 0/0", busy, mem_req); end
        run_op(0, 0, 200, 0);
        n_chk++; if (rd_n != N || rd_addr[0] !== 32'h1000 || done_cyc != 33 || (fw_n > 0 && fw_addr[0] !== 0)) begin
            n_fail++; $display("FAIL mid_restart rd=%0d first=%h done=%0d required 32/00001000/33", rd_n, rd_addr[0], done_cyc); end
    endtask

    initial begin
        for (int k = 0; k < N; k++) cache[k] = 32'hA5000000 + k;
        @(negedge clk);
        test_reset();
        @(negedge clk); reset = 0;
        @(negedge clk);
        test_clean_fill();
        test_dirty();
        test_ack_delay();
        test_ignored_inputs();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
